// File: rtl/yl3_display_arbiter.sv
// Round-robin arbiter and LOAD/READY sequencer feeding the YL-3 8-digit display interface.
// Optional periodic re-issue of the last frame is enabled with `define YL3_ARB_REFRESH_EN.
module yl3_display_arbiter #(
  parameter int NREQ           = 4,
  parameter int REFRESH_CYCLES = 50000000,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic [NREQ-1:0]    REQ,
  input  logic [64*NREQ-1:0] REQ_DATA,
  output logic [NREQ-1:0]    GNT,
  input  logic               DISP_READY,
  output logic               DISP_LOAD,
  output logic [63:0]        DISP_DATA,
  output logic [2:0]         OWNER,
  output logic               BUSY,
  output logic               ERR
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_DONE} state_t;

  state_t          state;
  logic [2:0]      ptr;
  logic            frame_valid;
  logic [TW-1:0]   tcnt;
  logic            tmo;
  logic            refresh_due;
  int              win;

  assign tmo = (tcnt == TW'(TIMEOUT_CYCLES - 1));

  // First set REQ after the pointer; scanning downward leaves the nearest one in win.
  always_comb begin
    win = 0;
    for (int k = NREQ; k >= 1; k--)
      if (REQ[(int'(ptr) + k) % NREQ]) win = (int'(ptr) + k) % NREQ;
  end

`ifdef YL3_ARB_REFRESH_EN
  localparam int RW = $clog2(REFRESH_CYCLES + 1);
  logic [RW-1:0] rcnt;
  logic          rsat;

  assign rsat        = (rcnt == RW'(REFRESH_CYCLES - 1));
  assign refresh_due = frame_valid && rsat;

  // Idle-time counter; saturates so an expired refresh stays pending until it is served.
  always_ff @(posedge CLK) begin
    if (!nRST)
      rcnt <= '0;
    else if (state == WAIT_DONE && DISP_READY && !tmo)
      rcnt <= '0;
    else if (state == IDLE && frame_valid && !rsat)
      rcnt <= rcnt + 1'b1;
  end
`else
  assign refresh_due = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state       <= IDLE;
      GNT         <= '0;
      DISP_LOAD   <= 1'b0;
      DISP_DATA   <= 64'h0;
      OWNER       <= 3'(NREQ - 1);
      ptr         <= 3'(NREQ - 1);
      BUSY        <= 1'b0;
      ERR         <= 1'b0;
      frame_valid <= 1'b0;
      tcnt        <= '0;
    end else begin
      GNT <= '0;
      ERR <= 1'b0;
      case (state)
        IDLE: begin
          if (|REQ) begin
            DISP_DATA   <= REQ_DATA[64*win +: 64];
            GNT         <= NREQ'(1) << win;
            OWNER       <= 3'(win);
            ptr         <= 3'(win);
            frame_valid <= 1'b1;
            state       <= LOAD;
            DISP_LOAD   <= 1'b1;
            BUSY        <= 1'b1;
            tcnt        <= '0;
          end else if (refresh_due) begin
            state     <= LOAD;
            DISP_LOAD <= 1'b1;
            BUSY      <= 1'b1;
            tcnt      <= '0;
          end
        end
        LOAD: begin
          if (tmo) begin
            ERR       <= 1'b1;
            DISP_LOAD <= 1'b0;
            BUSY      <= 1'b0;
            state     <= IDLE;
          end else if (!DISP_READY) begin
            DISP_LOAD <= 1'b0;
            state     <= WAIT_DONE;
            tcnt      <= '0;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (tmo) begin
            ERR   <= 1'b1;
            BUSY  <= 1'b0;
            state <= IDLE;
          end else if (DISP_READY) begin
            BUSY  <= 1'b0;
            state <= IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: begin
          DISP_LOAD <= 1'b0;
          BUSY      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_yl3_display_arbiter.sv
// Directed bench for yl3_display_arbiter: transaction-level model checked every cycle,
// display emulator driving READY, plus hand-computed expectations for each scenario.
module tb_yl3_display_arbiter;

  localparam int N  = 4;
  localparam int RC = 16;
  localparam int TO = 64;
`ifdef YL3_ARB_REFRESH_EN
  localparam bit REF_EN = 1'b1;
`else
  localparam bit REF_EN = 1'b0;
`endif

  logic             CLK = 1'b0;
  logic             nRST;
  logic [N-1:0]     REQ;
  logic [64*N-1:0]  REQ_DATA;
  logic [N-1:0]     GNT;
  logic             DISP_READY;
  logic             DISP_LOAD;
  logic [63:0]      DISP_DATA;
  logic [2:0]       OWNER;
  logic             BUSY;
  logic             ERR;

  yl3_display_arbiter #(.NREQ(N), .REFRESH_CYCLES(RC), .TIMEOUT_CYCLES(TO)) dut (
    .CLK(CLK), .nRST(nRST), .REQ(REQ), .REQ_DATA(REQ_DATA), .GNT(GNT),
    .DISP_READY(DISP_READY), .DISP_LOAD(DISP_LOAD), .DISP_DATA(DISP_DATA),
    .OWNER(OWNER), .BUSY(BUSY), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: phase 0 idle, 1 loading, 2 waiting for the display to finish.
  int          m_ph = 0, m_ptr = N-1, m_owner = N-1, m_age = 0, m_idle = 0;
  bit          m_valid = 0;
  logic [63:0] m_data = '0;
  logic [N-1:0] m_gnt = '0;
  bit          m_err = 0;

  task automatic model_step();
    bit was_valid;
    int w;
    m_gnt = '0;
    m_err = 0;
    if (!nRST) begin
      m_ph = 0; m_ptr = N-1; m_owner = N-1; m_data = '0;
      m_valid = 0; m_age = 0; m_idle = 0;
    end else begin
      case (m_ph)
        0: begin
          was_valid = m_valid;
          if (REQ != '0) begin
            w = -1;
            for (int k = 1; k <= N; k++)
              if (w < 0 && REQ[(m_ptr + k) % N]) w = (m_ptr + k) % N;
            m_gnt[w] = 1'b1;
            m_data   = REQ_DATA[64*w +: 64];
            m_owner  = w;
            m_ptr    = w;
            m_valid  = 1;
            m_ph     = 1;
            m_age    = 0;
          end else if (REF_EN && m_valid && m_idle == RC-1) begin
            m_ph  = 1;
            m_age = 0;
          end
          if (was_valid && m_idle < RC-1) m_idle++;
        end
        1: begin
          if (m_age == TO-1) begin m_err = 1; m_ph = 0; end
          else if (!DISP_READY) begin m_ph = 2; m_age = 0; end
          else m_age++;
        end
        default: begin
          if (m_age == TO-1) begin m_err = 1; m_ph = 0; end
          else if (DISP_READY) begin m_ph = 0; m_idle = 0; end
          else m_age++;
        end
      endcase
    end
  endtask

  task automatic compare();
    chk("m_gnt",   64'(GNT),       64'(m_gnt));
    chk("m_load",  64'(DISP_LOAD), 64'(m_ph == 1));
    chk("m_data",  DISP_DATA,      m_data);
    chk("m_owner", 64'(OWNER),     64'(m_owner));
    chk("m_busy",  64'(BUSY),      64'(m_ph != 0));
    chk("m_err",   64'(ERR),       64'(m_err));
  endtask

  // Display emulator: drops READY after seeing LOAD e_drop times, raises it e_busy later.
  int e_mode = 0, e_drop = 2, e_busy = 40, e_ld = 0, e_bz = 0;

  task automatic emu();
    if (DISP_READY) begin
      if (e_mode == 0 && DISP_LOAD) begin
        e_ld++;
        if (e_ld >= e_drop) begin DISP_READY = 1'b0; e_bz = 0; e_ld = 0; end
      end else e_ld = 0;
    end else begin
      e_bz++;
      if (e_bz >= e_busy) DISP_READY = 1'b1;
    end
  endtask

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
    model_step();
    compare();
    emu();
  endtask

  task automatic wait_gnt(input string name, output int n);
    n = 0;
    do begin step(); n++; end while (GNT == '0 && n < 50);
    if (GNT == '0) chk({name, "_timeout"}, 64'(GNT), 64'(1));
  endtask

  task automatic wait_idle(input string name, output bit err_seen);
    int n = 0;
    err_seen = 0;
    while (BUSY && n < 500) begin step(); n++; if (ERR) err_seen = 1; end
    if (BUSY) chk({name, "_timeout"}, 64'(BUSY), 64'(0));
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_gnt"},   64'(GNT),       64'(0));
    chk({name, "_load"},  64'(DISP_LOAD), 64'(0));
    chk({name, "_data"},  DISP_DATA,      64'h0);
    chk({name, "_owner"}, 64'(OWNER),     64'(3));
    chk({name, "_busy"},  64'(BUSY),      64'(0));
    chk({name, "_err"},   64'(ERR),       64'(0));
  endtask

  initial begin
    int n, idx;
    bit es, gseen;
    int order[$];
    int exp_order[5];
    logic [63:0] f;

    exp_order = '{0, 1, 2, 3, 0};
    nRST = 1'b0; REQ = '0; REQ_DATA = '0; DISP_READY = 1'b1;
    step(); step();
    check_reset_outputs("rst");
    nRST = 1'b1;

    // 1: single grant with a slow display
    f = "HELLO 01";
    REQ_DATA[63:0] = f;
    REQ = 4'b0001;
    e_busy = 40;
    wait_gnt("t1", n);
    chk("t1_latency", 64'(n), 64'(1));
    chk("t1_gnt", 64'(GNT), 64'(4'b0001));
    chk("t1_data", DISP_DATA, 64'h48454C4C4F203031);
    chk("t1_load", 64'(DISP_LOAD), 64'(1));
    REQ = '0;
    step();
    chk("t1_gnt_pulse", 64'(GNT), 64'(0));
    wait_idle("t1", es);
    chk("t1_err", 64'(es), 64'(0));
    chk("t1_busy", 64'(BUSY), 64'(0));

    // 5: idle after a grant -- refresh reload or nothing
    n = 0; gseen = 0;
    do begin step(); n++; if (GNT != '0) gseen = 1; end while (!DISP_LOAD && n < 1000);
`ifdef YL3_ARB_REFRESH_EN
    chk("t5_refresh_delay", 64'(n), 64'(16));
    chk("t5_refresh_data", DISP_DATA, 64'h48454C4C4F203031);
    chk("t5_no_gnt", 64'(gseen), 64'(0));
    chk("t5_owner", 64'(OWNER), 64'(0));
    wait_idle("t5", es);

    // 3: REQ arrives on the very cycle the refresh would fire
    repeat (15) step();
    f = "REQ1 WIN";
    REQ_DATA[127:64] = f;
    REQ = 4'b0010;
    step();
    chk("t3_gnt", 64'(GNT), 64'(4'b0010));
    chk("t3_data", DISP_DATA, 64'h524551312057494E);
    chk("t3_owner", 64'(OWNER), 64'(1));
    REQ = '0;
    wait_idle("t3", es);
`else
    chk("t5_no_reload", 64'(DISP_LOAD), 64'(0));
    chk("t5_no_gnt", 64'(gseen), 64'(0));
`endif

    // 2: all four requesting continuously
    nRST = 1'b0; step(); nRST = 1'b1;
    e_busy = 3;
    for (int i = 0; i < N; i++) REQ_DATA[64*i +: 64] = 64'hA0A0_0000_0000_0000 | 64'(i);
    REQ = 4'b1111;
    n = 0;
    while (order.size() < 5 && n < 400) begin
      step(); n++;
      if (GNT != '0) begin
        chk("t2_onehot", 64'($countones(GNT)), 64'(1));
        idx = 0;
        for (int k = 0; k < N; k++) if (GNT[k]) idx = k;
        chk("t2_owner", 64'(OWNER), 64'(idx));
        order.push_back(idx);
      end
    end
    REQ = '0;
    chk("t2_count", 64'(order.size()), 64'(5));
    for (int i = 0; i < order.size(); i++) chk("t2_order", 64'(order[i]), 64'(exp_order[i]));
    wait_idle("t2", es);

    // 4: display never drops READY -> timeout abort
    nRST = 1'b0; step(); nRST = 1'b1;
    e_mode = 1;
    f = "TIMEOUT!";
    REQ_DATA[191:128] = f;
    REQ = 4'b0100;
    wait_gnt("t4", n);
    REQ = '0;
    n = 0;
    do begin step(); n++; end while (!ERR && n < 200);
    chk("t4_err_delay", 64'(n), 64'(TO));
    chk("t4_load", 64'(DISP_LOAD), 64'(0));
    chk("t4_busy", 64'(BUSY), 64'(0));
    chk("t4_data", DISP_DATA, 64'h54494D454F555421);
    step();
    chk("t4_err_pulse", 64'(ERR), 64'(0));
    e_mode = 0;
    e_busy = 40;
    wait_idle("t4", es);

    // 6: reset while waiting for the display
    REQ = 4'b0001;
    wait_gnt("t6", n);
    REQ = '0;
    n = 0;
    while (!(BUSY && !DISP_LOAD) && n < 50) begin step(); n++; end
    chk("t6_in_wait", 64'(BUSY && !DISP_LOAD), 64'(1));
    nRST = 1'b0;
    step();
    check_reset_outputs("t6_rst");
    nRST = 1'b1;
    REQ = 4'b0100;
    step();
    chk("t6_gnt", 64'(GNT), 64'(4'b0100));
    chk("t6_owner", 64'(OWNER), 64'(2));
    REQ = '0;
    repeat (5) step();

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
